// File: rtl/bp_pkg.sv
// bp_pkg: shared scheduler FSM state and queued-update entry types
package bp_pkg;
  localparam int IP_MAX = 64;
  typedef enum logic {NORMAL, URGENT} state_t;
  typedef struct packed {
    logic [IP_MAX-1:0] ip;
    logic taken;
  } entry_t;
endpackage

// File: rtl/bp_if.sv
// bp_if: fetch lookup, resolved-branch update and shared predictor port signals
interface bp_if #(parameter int IP_W = 64);
  logic lk_valid;
  logic [IP_W-1:0] lk_ip;
  logic lk_ready;
  logic lk_prediction;
  logic rs_valid;
  logic [IP_W-1:0] rs_ip;
  logic rs_taken;
  logic rs_ready;
  logic [IP_W-1:0] bp_ip;
  logic bp_upd;
  logic bp_taken;
  logic bp_prediction;
  logic urgent;
  modport master(
    output lk_valid, lk_ip, rs_valid, rs_ip, rs_taken, bp_prediction,
    input lk_ready, lk_prediction, rs_ready, bp_ip, bp_upd, bp_taken, urgent
  );
  modport slave(
    input lk_valid, lk_ip, rs_valid, rs_ip, rs_taken, bp_prediction,
    output lk_ready, lk_prediction, rs_ready, bp_ip, bp_upd, bp_taken, urgent
  );
endinterface

// File: rtl/bp_update_fifo.sv
// bp_update_fifo: DEPTH-entry update queue exposing head and all entries oldest-first
module bp_update_fifo import bp_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  entry_t push_data,
  output entry_t head,
  output entry_t [DEPTH-1:0] entries,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  entry_t mem [DEPTH];
  logic [AW-1:0] wr;
  logic [AW-1:0] rd;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      wr <= wr + AW'(push);
      rd <= rd + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr] <= push_data;
  always_comb
    for (int i = 0; i < DEPTH; i++) entries[i] = mem[rd + AW'(i)];
  assign head = mem[rd];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/bp_port_scheduler.sv
// bp_port_scheduler: shares one predictor port between lookups and queued updates; define BP_FWD_EN for lookup forwarding from queued updates
module bp_port_scheduler #(
  parameter int DEPTH = 4,
  parameter int IP_W = 64
) (
  input logic clk,
  input logic reset,
  bp_if.slave bus
);
  import bp_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;
  state_t state;
  state_t state_next;
  logic push;
  logic pop;
  logic full;
  logic empty;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  entry_t head;
  entry_t [DEPTH-1:0] entries;
  bp_update_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .push_data('{ip: IP_MAX'(bus.rs_ip), taken: bus.rs_taken}),
    .head(head),
    .entries(entries),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= NORMAL;
    else state <= state_next;
  always_comb begin
    count_next = count + CW'(push) - CW'(pop);
    state_next = state == NORMAL ? (full ? URGENT : NORMAL)
                                 : (count_next <= CW'(DEPTH / 2) ? NORMAL : URGENT);
  end
  always_comb begin
    bus.lk_ready = state == NORMAL && bus.lk_valid;
    bus.rs_ready = !full;
    bus.urgent = state == URGENT;
    push = bus.rs_valid && !full;
    pop = !empty && !bus.lk_ready;
    bus.bp_upd = pop;
    bus.bp_ip = bus.lk_ready ? bus.lk_ip : pop ? IP_W'(head.ip) : '0;
    bus.bp_taken = pop && head.taken;
  end
`ifdef BP_FWD_EN
  logic fwd_hit;
  logic fwd_taken;
  always_comb begin
    fwd_hit = 1'b0;
    fwd_taken = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i) < count && entries[i].ip == IP_MAX'(bus.lk_ip)) begin
        fwd_hit = 1'b1;
        fwd_taken = entries[i].taken;
      end
  end
  assign bus.lk_prediction = fwd_hit ? fwd_taken : bus.bp_prediction;
`else
  logic unused_entries;
  assign unused_entries = ^entries;
  assign bus.lk_prediction = bus.bp_prediction;
`endif
endmodule

// File: tb/tb_bp_port_scheduler.sv
// tb_bp_port_scheduler: directed scenarios plus randomized run against a queue-based reference model
module tb_bp_port_scheduler;
  localparam int DEPTH = 4;
  localparam int IP_W = 64;
  typedef struct {
    logic [IP_W-1:0] ip;
    logic taken;
  } ent_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  bp_if #(.IP_W(IP_W)) bus ();
  bp_port_scheduler #(.DEPTH(DEPTH), .IP_W(IP_W)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic drive(input logic lkv, input logic [IP_W-1:0] lkip, input logic rsv,
                       input logic [IP_W-1:0] rsip, input logic rst_t, input logic bpp);
    @(negedge clk);
    bus.lk_valid = lkv;
    bus.lk_ip = lkip;
    bus.rs_valid = rsv;
    bus.rs_ip = rsip;
    bus.rs_taken = rst_t;
    bus.bp_prediction = bpp;
    #1;
  endtask
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.lk_valid = 1'b0;
    bus.rs_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.lk_valid = 1'b1;
    bus.lk_ip = 64'h40;
    bus.rs_valid = 1'b0;
    bus.rs_ip = '0;
    bus.rs_taken = 1'b0;
    bus.bp_prediction = 1'b1;
    #1;
    total++; if (bus.lk_ready !== 1'b1) begin bad++; $display("FAIL reset_lk_ready got=%b exp=1", bus.lk_ready); end
    total++; if (bus.lk_prediction !== 1'b1) begin bad++; $display("FAIL reset_lk_prediction got=%b exp=1", bus.lk_prediction); end
    total++; if (bus.bp_upd !== 1'b0) begin bad++; $display("FAIL reset_bp_upd got=%b exp=0", bus.bp_upd); end
    total++; if (bus.rs_ready !== 1'b1) begin bad++; $display("FAIL reset_rs_ready got=%b exp=1", bus.rs_ready); end
    total++; if (bus.urgent !== 1'b0) begin bad++; $display("FAIL reset_urgent got=%b exp=0", bus.urgent); end
    total++; if (bus.bp_ip !== 64'h40) begin bad++; $display("FAIL reset_bp_ip got=%h exp=40", bus.bp_ip); end
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_fill_urgent();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 64'h40, 1'b1, 64'h100 + 64'(i * 4), i[0], 1'b0);
      total++; if (bus.rs_ready !== 1'b1) begin bad++; $display("FAIL fill_rs_ready[%0d] got=%b exp=1", i, bus.rs_ready); end
    end
    drive(1'b1, 64'h40, 1'b0, '0, 1'b0, 1'b0);
    total++; if (bus.rs_ready !== 1'b0) begin bad++; $display("FAIL full_rs_ready got=%b exp=0", bus.rs_ready); end
    total++; if (bus.urgent !== 1'b0) begin bad++; $display("FAIL full_urgent got=%b exp=0", bus.urgent); end
    total++; if (bus.lk_ready !== 1'b1) begin bad++; $display("FAIL full_lk_ready got=%b exp=1", bus.lk_ready); end
    total++; if (bus.bp_upd !== 1'b0) begin bad++; $display("FAIL full_bp_upd got=%b exp=0", bus.bp_upd); end
    drive(1'b1, 64'h40, 1'b0, '0, 1'b0, 1'b0);
    total++; if (bus.urgent !== 1'b1) begin bad++; $display("FAIL urgent_set got=%b exp=1", bus.urgent); end
    total++; if (bus.lk_ready !== 1'b0) begin bad++; $display("FAIL urgent_lk_ready got=%b exp=0", bus.lk_ready); end
    total++; if (bus.bp_upd !== 1'b1) begin bad++; $display("FAIL urgent_bp_upd got=%b exp=1", bus.bp_upd); end
    total++; if (bus.bp_ip !== 64'h100) begin bad++; $display("FAIL urgent_bp_ip got=%h exp=100", bus.bp_ip); end
    total++; if (bus.bp_taken !== 1'b0) begin bad++; $display("FAIL urgent_bp_taken got=%b exp=0", bus.bp_taken); end
  endtask
  task automatic test_drain();
    drive(1'b1, 64'h40, 1'b0, '0, 1'b0, 1'b0);
    total++; if (bus.urgent !== 1'b1) begin bad++; $display("FAIL drain3_urgent got=%b exp=1", bus.urgent); end
    total++; if (bus.bp_ip !== 64'h104) begin bad++; $display("FAIL drain3_bp_ip got=%h exp=104", bus.bp_ip); end
    total++; if (bus.bp_taken !== 1'b1) begin bad++; $display("FAIL drain3_bp_taken got=%b exp=1", bus.bp_taken); end
    total++; if (bus.rs_ready !== 1'b1) begin bad++; $display("FAIL drain3_rs_ready got=%b exp=1", bus.rs_ready); end
    drive(1'b1, 64'h40, 1'b0, '0, 1'b0, 1'b0);
    total++; if (bus.urgent !== 1'b0) begin bad++; $display("FAIL drain2_urgent got=%b exp=0", bus.urgent); end
    total++; if (bus.lk_ready !== 1'b1) begin bad++; $display("FAIL drain2_lk_ready got=%b exp=1", bus.lk_ready); end
    total++; if (bus.bp_upd !== 1'b0) begin bad++; $display("FAIL drain2_bp_upd got=%b exp=0", bus.bp_upd); end
    total++; if (bus.bp_ip !== 64'h40) begin bad++; $display("FAIL drain2_bp_ip got=%h exp=40", bus.bp_ip); end
  endtask
  task automatic test_back_to_back();
    drive(1'b0, '0, 1'b1, 64'h200, 1'b1, 1'b0);
    total++; if (bus.bp_upd !== 1'b1) begin bad++; $display("FAIL b2b_bp_upd got=%b exp=1", bus.bp_upd); end
    total++; if (bus.bp_ip !== 64'h108) begin bad++; $display("FAIL b2b_oldest_ip got=%h exp=108", bus.bp_ip); end
    total++; if (bus.bp_taken !== 1'b0) begin bad++; $display("FAIL b2b_oldest_taken got=%b exp=0", bus.bp_taken); end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    total++; if (bus.bp_ip !== 64'h10C || bus.bp_taken !== 1'b1) begin bad++; $display("FAIL b2b_second got=%h/%b exp=10c/1", bus.bp_ip, bus.bp_taken); end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    total++; if (bus.bp_ip !== 64'h200 || bus.bp_taken !== 1'b1) begin bad++; $display("FAIL b2b_third got=%h/%b exp=200/1", bus.bp_ip, bus.bp_taken); end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    total++; if (bus.bp_upd !== 1'b0 || bus.bp_ip !== '0 || bus.bp_taken !== 1'b0) begin bad++; $display("FAIL idle_port got=%b/%h/%b exp=0/0/0", bus.bp_upd, bus.bp_ip, bus.bp_taken); end
  endtask
  task automatic test_reset_urgent();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 64'h40, 1'b1, 64'h300 + 64'(i), 1'b1, 1'b0);
    drive(1'b1, 64'h40, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 64'h40, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 64'h40, 1'b0, '0, 1'b0, 1'b0);
    total++; if (bus.urgent !== 1'b1) begin bad++; $display("FAIL pre_reset_urgent got=%b exp=1", bus.urgent); end
    reset = 1'b1;
    #1;
    total++; if (bus.urgent !== 1'b0) begin bad++; $display("FAIL async_reset_urgent got=%b exp=0", bus.urgent); end
    total++; if (bus.rs_ready !== 1'b1) begin bad++; $display("FAIL async_reset_rs_ready got=%b exp=1", bus.rs_ready); end
    total++; if (bus.lk_ready !== 1'b1) begin bad++; $display("FAIL async_reset_lk_ready got=%b exp=1", bus.lk_ready); end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    total++; if (bus.bp_upd !== 1'b0) begin bad++; $display("FAIL reset_discard_bp_upd got=%b exp=0", bus.bp_upd); end
  endtask
  task automatic test_forward();
    logic exp;
    apply_reset();
    drive(1'b1, 64'h300, 1'b1, 64'h100, 1'b1, 1'b1);
    drive(1'b1, 64'h300, 1'b1, 64'h100, 1'b0, 1'b1);
    drive(1'b1, 64'h100, 1'b0, '0, 1'b0, 1'b1);
`ifdef BP_FWD_EN
    exp = 1'b0;
`else
    exp = 1'b1;
`endif
    total++; if (bus.lk_prediction !== exp) begin bad++; $display("FAIL fwd_match got=%b exp=%b", bus.lk_prediction, exp); end
    total++; if (bus.bp_ip !== 64'h100 || bus.lk_ready !== 1'b1) begin bad++; $display("FAIL fwd_port got=%h/%b exp=100/1", bus.bp_ip, bus.lk_ready); end
    drive(1'b1, 64'h300, 1'b0, '0, 1'b0, 1'b1);
    total++; if (bus.lk_prediction !== 1'b1) begin bad++; $display("FAIL fwd_miss got=%b exp=1", bus.lk_prediction); end
  endtask
  task automatic test_random();
    ent_t q[$];
    bit urg;
    int sz;
    int lk_pct;
    logic rst_now, lkv, rsv, rst_t, bpp, exp_lk_ready, exp_rs_ready, drain, exp_taken, exp_pred;
    logic [IP_W-1:0] lkip, rsip, exp_ip;
    apply_reset();
    urg = 1'b0;
    lk_pct = 90;
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) lk_pct = $urandom_range(0, 2) == 0 ? 10 : $urandom_range(0, 1) ? 50 : 92;
      rst_now = $urandom_range(0, 199) == 0;
      lkv = $urandom_range(0, 99) < lk_pct;
      rsv = $urandom_range(0, 99) < 70;
      lkip = 64'h100 + 64'($urandom_range(0, 3)) * 4;
      rsip = 64'h100 + 64'($urandom_range(0, 3)) * 4;
      rst_t = 1'($urandom);
      bpp = 1'($urandom);
      @(negedge clk);
      reset = rst_now;
      bus.lk_valid = lkv;
      bus.lk_ip = lkip;
      bus.rs_valid = rsv;
      bus.rs_ip = rsip;
      bus.rs_taken = rst_t;
      bus.bp_prediction = bpp;
      if (rst_now) begin
        q.delete();
        urg = 1'b0;
      end
      #1;
      exp_lk_ready = !urg && lkv;
      exp_rs_ready = q.size() < DEPTH;
      drain = q.size() != 0 && !exp_lk_ready;
      exp_ip = exp_lk_ready ? lkip : drain ? q[0].ip : '0;
      exp_taken = drain ? q[0].taken : 1'b0;
      exp_pred = bpp;
`ifdef BP_FWD_EN
      foreach (q[k]) if (q[k].ip == lkip) exp_pred = q[k].taken;
`endif
      total++; if (bus.lk_ready !== exp_lk_ready) begin bad++; $display("FAIL rnd_lk_ready n=%0d got=%b exp=%b", n, bus.lk_ready, exp_lk_ready); end
      total++; if (bus.rs_ready !== exp_rs_ready) begin bad++; $display("FAIL rnd_rs_ready n=%0d got=%b exp=%b", n, bus.rs_ready, exp_rs_ready); end
      total++; if (bus.urgent !== urg) begin bad++; $display("FAIL rnd_urgent n=%0d got=%b exp=%b", n, bus.urgent, urg); end
      total++; if (bus.bp_upd !== drain) begin bad++; $display("FAIL rnd_bp_upd n=%0d got=%b exp=%b", n, bus.bp_upd, drain); end
      total++; if (bus.bp_ip !== exp_ip) begin bad++; $display("FAIL rnd_bp_ip n=%0d got=%h exp=%h", n, bus.bp_ip, exp_ip); end
      total++; if (bus.bp_taken !== exp_taken) begin bad++; $display("FAIL rnd_bp_taken n=%0d got=%b exp=%b", n, bus.bp_taken, exp_taken); end
      if (exp_lk_ready) begin
        total++; if (bus.lk_prediction !== exp_pred) begin bad++; $display("FAIL rnd_lk_prediction n=%0d got=%b exp=%b", n, bus.lk_prediction, exp_pred); end
      end
      if (!rst_now) begin
        sz = q.size();
        if (drain) void'(q.pop_front());
        if (rsv && exp_rs_ready) q.push_back('{ip: rsip, taken: rst_t});
        urg = urg ? q.size() > DEPTH / 2 : sz == DEPTH;
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    bus.lk_valid = 1'b0;
    bus.lk_ip = '0;
    bus.rs_valid = 1'b0;
    bus.rs_ip = '0;
    bus.rs_taken = 1'b0;
    bus.bp_prediction = 1'b0;
    test_reset();
    test_fill_urgent();
    test_drain();
    test_back_to_back();
    test_reset_urgent();
    test_forward();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bp_port_scheduler.md
BP_PORT_SCHEDULER -- requirements
Module: bp_port_scheduler

Interface
REQ-001 Parameter DEPTH, default 4, SHALL be the update-queue depth (power of two, 2..16).
REQ-002 Parameter IP_W, default 64, SHALL be the instruction-pointer width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 lk_valid  input  1  SHALL mark a fetch-side prediction lookup request.
REQ-006 lk_ip  input  IP_W  SHALL be the lookup IP.
REQ-007 lk_ready  output  1  SHALL mark that the lookup is served this cycle.
REQ-008 lk_prediction  output  1  SHALL be the prediction for the served lookup, valid only when lk_valid && lk_ready.
REQ-009 rs_valid  input  1  SHALL mark a resolved branch (update request).
REQ-010 rs_ip  input  IP_W  SHALL be the resolved-branch IP.
REQ-011 rs_taken  input  1  SHALL be the resolved direction.
REQ-012 rs_ready  output  1  SHALL be high when the queue can accept an update (count < DEPTH).
REQ-013 bp_ip  output  IP_W  SHALL drive the predictor's shared IP port.
REQ-014 bp_upd  output  1  SHALL be high when the port carries an update, low when it carries a lookup.
REQ-015 bp_taken  output  1  SHALL be the update direction; 0 when bp_upd=0.
REQ-016 bp_prediction  input  1  SHALL be the predictor's combinational prediction for bp_ip.
REQ-017 urgent  output  1  SHALL reflect FSM state URGENT.

Function
REQ-018 Updates SHALL enter a DEPTH-entry FIFO on rs_valid && rs_ready; pointers wrap modulo DEPTH; count is clog2(DEPTH)+1 bits.
REQ-019 The port SHALL serve exactly one operation per cycle, chosen by a two-state FSM: NORMAL, URGENT.
REQ-020 NORMAL: a pending lookup SHALL win (lk_ready=1); otherwise the FIFO head SHALL drain (bp_upd=1).
REQ-021 URGENT: the FIFO head SHALL drain every cycle; lk_ready=0.
REQ-022 NORMAL->URGENT SHALL occur when count==DEPTH at a clock edge; URGENT->NORMAL when count <= DEPTH/2 after the edge.
REQ-023 Simultaneous enqueue and drain SHALL leave count unchanged; enqueue SHALL be accepted on the same edge a full queue drains only if rs_ready was high (no same-cycle pass-through).
REQ-024 When the FIFO is empty and no lookup is pending, bp_upd=0, bp_ip=0, bp_taken=0.
REQ-025 lk_prediction SHALL equal bp_prediction with zero-cycle latency; updates reach the predictor in FIFO order, minimum 1 cycle after acceptance.
REQ-026 rs_ready SHALL depend only on registered count (no combinational path from lk_valid).

Reset
REQ-027 reset SHALL asynchronously clear pointers and count, set FSM to NORMAL; outputs: rs_ready=1, urgent=0, bp_upd=0, lk_ready=lk_valid.
REQ-028 Reset mid-operation SHALL discard all queued updates; FIFO payload need not be cleared.

Configuration
REQ-029 With BP_FWD_EN defined, a served lookup whose lk_ip equals any queued entry's IP SHALL return the youngest matching entry's taken value instead of bp_prediction.
REQ-030 Without BP_FWD_EN, lk_prediction SHALL always equal bp_prediction and no IP comparators exist.

Structure
REQ-031 A shared package bp_pkg SHALL hold the FSM state typedef (NORMAL, URGENT) and the update-entry struct {ip, taken}.
REQ-032 The FIFO SHALL be a sub-module bp_update_fifo (push/pop/full/empty/count/entries out).

Verification
REQ-033 Reset, idle: lk_valid=1, lk_ip=0x40, bp_prediction=1 -> lk_ready=1, lk_prediction=1, bp_upd=0.
REQ-034 Four rs_valid pushes with lk_valid held high -> count=4, rs_ready=0, next cycle urgent=1, lk_ready=0.
REQ-035 From URGENT at count=4, no new pushes -> two drains in order, urgent=0 when count=2, lk_ready=1 next cycle.
REQ-036 Push and drain same cycle at count=2 -> count stays 2, drained entry is oldest.
REQ-037 BP_FWD_EN: queue {0x100,T},{0x100,NT}, lookup 0x100 with bp_prediction=1 -> lk_prediction=0.
REQ-038 reset asserted with count=3 in URGENT -> immediately count=0, urgent=0, rs_ready=1.
